// File: rtl/rx_frame_extract.sv
// -----------------------------------------------------------------------------
// rx_frame_extract
//
// Front end of the Ethernet RX path. Strips preamble/SFD from the raw GMII byte
// stream and forwards the frame bytes (destination MAC onward, FCS included)
// one cycle later on rx_en/rx_data. Captures the big-endian 16-bit segment
// number from the header, flags each frame good or bad at its end, and keeps
// running totals of received and bad frames.
//
// Optional feature, selected by the macro RX_FCS_CHECK_EN:
//   defined   - CRC-32 over all bytes after SFD; a frame is good only if the
//               residue matches. Adds the fcs_err output.
//   undefined - no CRC logic, no fcs_err port; FCS bytes are still forwarded.
//
// Ports
//   clk          in   1   clock
//   rst          in   1   synchronous, active-high reset
//   gmii_rx_dv   in   1   GMII data valid
//   gmii_rx_er   in   1   GMII receive error
//   gmii_rxd     in   8   GMII data byte
//   rx_en        out  1   frame byte valid, contiguous for one frame
//   rx_data      out  8   frame byte
//   seg          out  16  segment number of the current/last frame
//   frame_done   out  1   one-cycle pulse at the end of every frame that reached DATA
//   frame_ok     out  1   qualifies frame_done: 1 = good frame
//   fcs_err      out  1   (RX_FCS_CHECK_EN only) pulses with frame_done on FCS failure
//   frames_rx    out  32  count of frame_done pulses (wraps)
//   frames_bad   out  32  count of frame_done pulses with frame_ok = 0 (wraps)
// -----------------------------------------------------------------------------
module rx_frame_extract #(
    parameter int SEG_OFFSET = 14,    // byte index after SFD of the seg MSB
    parameter int MAX_LEN    = 1518,  // longest good frame, FCS included
    parameter int MIN_LEN    = 64     // shortest good frame, FCS included
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    input  logic [7:0]  gmii_rxd,
    output logic        rx_en,
    output logic [7:0]  rx_data,
    output logic [15:0] seg,
    output logic        frame_done,
    output logic        frame_ok,
`ifdef RX_FCS_CHECK_EN
    output logic        fcs_err,
`endif
    output logic [31:0] frames_rx,
    output logic [31:0] frames_bad
);

    // The byte counter is 11 bits wide; MAX_LEN+1 must fit in it.
    localparam logic [10:0] L_MAX_LEN = 11'(MAX_LEN);
    localparam logic [10:0] L_MIN_LEN = 11'(MIN_LEN);
    localparam logic [10:0] L_CNT_SAT = 11'(MAX_LEN + 1);
    localparam logic [10:0] L_SEG_MSB = 11'(SEG_OFFSET);
    localparam logic [10:0] L_SEG_LSB = 11'(SEG_OFFSET + 1);

    localparam logic [7:0]  L_PREAMBLE = 8'h55;
    localparam logic [7:0]  L_SFD      = 8'hD5;

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_DROP
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;

    logic         w_sfd;        // SFD accepted: a new frame starts next cycle
    logic         w_fwd;        // current byte is forwarded
    logic         w_cnt_inc;    // current byte counts towards the frame length
    logic         w_done;       // frame ends this cycle
    logic         w_abort;      // frame ends because of rx_er or overrun
    logic         w_overrun;    // current byte would exceed MAX_LEN
    logic         w_len_ok;
    logic         w_fcs_ok;
    logic         w_ok_nxt;

    logic         r_rx_en;
    logic [7:0]   r_rx_data;
    logic [15:0]  r_seg;
    logic [7:0]   r_seg_msb;
    logic         r_frame_done;
    logic         r_frame_ok;
    logic [31:0]  r_frames_rx;
    logic [31:0]  r_frames_bad;
    logic [10:0]  r_byte_cnt;   // bytes received since SFD, saturating

`ifdef RX_FCS_CHECK_EN
    // Reflected CRC-32 (0x04C11DB7 reversed = 0xEDB88320), one bit per step,
    // data LSB first as it arrives on the wire.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ ((c[0] ^ d[i]) ? 32'hEDB88320 : 32'h0000_0000);
        end
        return c;
    endfunction

    function automatic logic [31:0] bit_rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31 - i];
        end
        return r;
    endfunction

    logic [31:0] r_crc;
    logic        r_fcs_err;

    // The shift register holds the residue bit-reversed; after data plus a
    // correct FCS it reads 0xDEBB20E3, i.e. 0xC704DD7B in normal bit order.
    assign w_fcs_ok = (bit_rev32(r_crc) == 32'hC704DD7B);
`else
    assign w_fcs_ok = 1'b1;
`endif

    assign w_overrun = (r_byte_cnt >= L_MAX_LEN);
    assign w_len_ok  = (r_byte_cnt >= L_MIN_LEN) && (r_byte_cnt <= L_MAX_LEN);
    assign w_ok_nxt  = w_done && !w_abort && w_len_ok && w_fcs_ok;

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values; combinational blocks use blocking ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_WAIT_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // FSM next-state and per-byte control
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        w_state_nxt = r_state;
        w_sfd       = 1'b0;
        w_fwd       = 1'b0;
        w_cnt_inc   = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;

        case (r_state)
            // After reset, a frame may be in flight; wait for a gap.
            S_WAIT_IDLE: begin
                if (!gmii_rx_dv) begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_IDLE: begin
                if (gmii_rx_dv) begin
                    w_state_nxt = (gmii_rxd == L_PREAMBLE) ? S_PREAMBLE : S_DROP;
                end
            end

            S_PREAMBLE: begin
                if (!gmii_rx_dv) begin
                    w_state_nxt = S_IDLE;
                end else if (gmii_rx_er) begin
                    w_state_nxt = S_DROP;
                end else if (gmii_rxd == L_SFD) begin
                    w_state_nxt = S_DATA;
                    w_sfd       = 1'b1;
                end else if (gmii_rxd != L_PREAMBLE) begin
                    w_state_nxt = S_DROP;
                end
            end

            S_DATA: begin
                // rx_er wins over a simultaneous rx_dv drop: the frame is
                // aborted, still with a single frame_done.
                if (gmii_rx_er) begin
                    w_state_nxt = S_DROP;
                    w_done      = 1'b1;
                    w_abort     = 1'b1;
                end else if (!gmii_rx_dv) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end else if (w_overrun) begin
                    // The offending byte is counted but never forwarded.
                    w_state_nxt = S_DROP;
                    w_cnt_inc   = 1'b1;
                    w_done      = 1'b1;
                    w_abort     = 1'b1;
                end else begin
                    w_fwd       = 1'b1;
                    w_cnt_inc   = 1'b1;
                end
            end

            S_DROP: begin
                if (!gmii_rx_dv) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_WAIT_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath: forwarding, length, seg capture, status and counters
    // ---------------------------------------------------------------------
    // NOTE: every register here, the counters included, is cleared by the
    // synchronous reset so all outputs read 0 the cycle after rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_en      <= 1'b0;
            r_rx_data    <= 8'h00;
            r_seg        <= 16'h0000;
            r_seg_msb    <= 8'h00;
            r_frame_done <= 1'b0;
            r_frame_ok   <= 1'b0;
            r_frames_rx  <= 32'h0;
            r_frames_bad <= 32'h0;
            r_byte_cnt   <= 11'd0;
        end else begin
            r_rx_en      <= w_fwd;
            r_frame_done <= w_done;
            r_frame_ok   <= w_ok_nxt;

            if (w_fwd) begin
                r_rx_data <= gmii_rxd;
            end

            if (w_sfd) begin
                r_byte_cnt <= 11'd0;
            end else if (w_cnt_inc && (r_byte_cnt != L_CNT_SAT)) begin
                r_byte_cnt <= r_byte_cnt + 11'd1;
            end

            // seg changes together with the LSB byte appearing on rx_data;
            // a runt that never reaches the LSB leaves it untouched.
            if (w_fwd && (r_byte_cnt == L_SEG_MSB)) begin
                r_seg_msb <= gmii_rxd;
            end
            if (w_fwd && (r_byte_cnt == L_SEG_LSB)) begin
                r_seg <= {r_seg_msb, gmii_rxd};
            end

            if (w_done) begin
                r_frames_rx <= r_frames_rx + 32'd1;
            end
            if (w_done && !w_ok_nxt) begin
                r_frames_bad <= r_frames_bad + 32'd1;
            end
        end
    end

`ifdef RX_FCS_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc     <= 32'hFFFF_FFFF;
            r_fcs_err <= 1'b0;
        end else begin
            if (w_sfd) begin
                r_crc <= 32'hFFFF_FFFF;
            end else if (w_fwd) begin
                r_crc <= crc32_byte(r_crc, gmii_rxd);
            end
            // Only a frame that ended cleanly has a meaningful FCS.
            r_fcs_err <= w_done && !w_abort && !w_fcs_ok;
        end
    end

    assign fcs_err = r_fcs_err;
`endif

    assign rx_en      = r_rx_en;
    assign rx_data    = r_rx_data;
    assign seg        = r_seg;
    assign frame_done = r_frame_done;
    assign frame_ok   = r_frame_ok;
    assign frames_rx  = r_frames_rx;
    assign frames_bad = r_frames_bad;

endmodule

// File: tb/tb_rx_frame_extract.sv
// -----------------------------------------------------------------------------
// tb_rx_frame_extract
//
// Directed bench for rx_frame_extract. Frames are built in fbuf with a known
// byte pattern, seg bytes at index 14/15 and a computed FCS, then driven on
// GMII. A negedge monitor records forwarded bytes and frame_done results.
// Works with and without RX_FCS_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_rx_frame_extract;

`ifdef RX_FCS_CHECK_EN
    localparam bit FCS_EN = 1'b1;
`else
    localparam bit FCS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic [7:0]  gmii_rxd;
    logic        rx_en;
    logic [7:0]  rx_data;
    logic [15:0] seg;
    logic        frame_done;
    logic        frame_ok;
`ifdef RX_FCS_CHECK_EN
    logic        fcs_err;
`endif
    logic [31:0] frames_rx;
    logic [31:0] frames_bad;

    always #5 clk = ~clk;

    rx_frame_extract dut (
        .clk        (clk),
        .rst        (rst),
        .gmii_rx_dv (gmii_rx_dv),
        .gmii_rx_er (gmii_rx_er),
        .gmii_rxd   (gmii_rxd),
        .rx_en      (rx_en),
        .rx_data    (rx_data),
        .seg        (seg),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
`ifdef RX_FCS_CHECK_EN
        .fcs_err    (fcs_err),
`endif
        .frames_rx  (frames_rx),
        .frames_bad (frames_bad)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] fbuf [0:1599];

    // ---------------- monitor (sole writer of these) ----------------
    logic [7:0] got_q [$];
    int         done_cnt     = 0;
    int         bursts       = 0;
    int         done_at_fall = 0;
    logic       last_ok      = 1'b0;
    logic       prev_en      = 1'b0;
`ifdef RX_FCS_CHECK_EN
    logic       last_fcs     = 1'b0;
`endif

    always @(negedge clk) begin
        if (rx_en === 1'b1) got_q.push_back(rx_data);
        if (rx_en === 1'b1 && prev_en !== 1'b1) bursts++;
        if (frame_done === 1'b1) begin
            done_cnt++;
            last_ok = frame_ok;
            if (prev_en === 1'b1 && rx_en === 1'b0) done_at_fall++;
`ifdef RX_FCS_CHECK_EN
            last_fcs = fcs_err;
`endif
        end
        prev_en = rx_en;
    end

    // ---------------- per-frame snapshots (written by the initial block) ----------------
    int   base_len, base_done, base_bursts, base_fall;
    logic lat_en0, lat_en1;
    logic [7:0] lat_d1;
    logic post_en, post_done;
    logic [15:0] post_seg;
    logic [31:0] post_rx, post_bad;
    int   exp_rx  = 0;
    int   exp_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference CRC-32 (IEEE 802.3): XOR byte in, then eight LSB-first shifts.
    function automatic logic [31:0] ref_crc(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, fbuf[i]};
            for (int b = 0; b < 8; b++) begin
                if (c[0]) c = (c >> 1) ^ 32'hEDB88320;
                else      c = c >> 1;
            end
        end
        return c;
    endfunction

    task automatic build(input int len, input logic [7:0] hi, input logic [7:0] lo);
        logic [31:0] fcs;
        for (int i = 0; i < len; i++) fbuf[i] = 8'((i * 7 + 3) & 8'hFF);
        if (len > 15) begin
            fbuf[14] = hi;
            fbuf[15] = lo;
        end
        fcs = ~ref_crc(len - 4);
        fbuf[len - 4] = fcs[7:0];
        fbuf[len - 3] = fcs[15:8];
        fbuf[len - 2] = fcs[23:16];
        fbuf[len - 1] = fcs[31:24];
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            gmii_rx_dv = 1'b0;
            gmii_rx_er = 1'b0;
            gmii_rxd   = 8'h00;
        end
    endtask

    // er_idx / rst_idx < 0 disables that event; er_on_end raises rx_er in
    // the cycle rx_dv drops.
    task automatic send_frame(input int len, input int er_idx, input int rst_idx, input bit er_on_end);
        base_len    = got_q.size();
        base_done   = done_cnt;
        base_bursts = bursts;
        base_fall   = done_at_fall;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            gmii_rx_dv = 1'b1;
            gmii_rx_er = 1'b0;
            gmii_rxd   = (i == 7) ? 8'hD5 : 8'h55;
        end
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == 0) lat_en0 = rx_en;
            if (i == 1) begin
                lat_en1 = rx_en;
                lat_d1  = rx_data;
            end
            if (rst_idx >= 0 && i == rst_idx + 1) begin
                rst       = 1'b0;
                post_en   = rx_en;
                post_done = frame_done;
                post_seg  = seg;
                post_rx   = frames_rx;
                post_bad  = frames_bad;
            end
            if (i == rst_idx) rst = 1'b1;
            gmii_rx_er = (i == er_idx);
            gmii_rxd   = fbuf[i];
        end
        @(negedge clk);
        gmii_rx_dv = 1'b0;
        gmii_rx_er = er_on_end;
        gmii_rxd   = 8'h00;
        idle(12);
    endtask

    function automatic int data_mism(input int base, input int n);
        int m;
        m = 0;
        for (int i = 0; i < n && (base + i) < got_q.size(); i++)
            if (got_q[base + i] !== fbuf[i]) m++;
        return m;
    endfunction

    task automatic check_frame(input string t, input int exp_len, input int exp_done,
                               input logic exp_ok, input logic [15:0] exp_seg);
        int n;
        n = got_q.size() - base_len;
        check({t, "_len"},   32'(n), 32'(exp_len));
        check({t, "_data"},  32'(data_mism(base_len, exp_len)), 32'd0);
        check({t, "_done"},  32'(done_cnt - base_done), 32'(exp_done));
        if (exp_done > 0) check({t, "_ok"}, {31'd0, last_ok}, {31'd0, exp_ok});
        check({t, "_seg"},   {16'd0, seg}, {16'd0, exp_seg});
        check({t, "_frx"},   frames_rx,  32'(exp_rx));
        check({t, "_fbad"},  frames_bad, 32'(exp_bad));
    endtask

    initial begin
        rst        = 1'b1;
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        gmii_rxd   = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(3);

        // Reset state
        check("rst_rx_en",   {31'd0, rx_en}, 32'd0);
        check("rst_done",    {31'd0, frame_done}, 32'd0);
        check("rst_ok",      {31'd0, frame_ok}, 32'd0);
        check("rst_seg",     {16'd0, seg}, 32'd0);
        check("rst_frx",     frames_rx, 32'd0);
        check("rst_fbad",    frames_bad, 32'd0);

        // 1: good 64-byte frame, seg 0x1234
        build(64, 8'h12, 8'h34);
        send_frame(64, -1, -1, 1'b0);
        exp_rx = 1;
        check_frame("t1", 64, 1, 1'b1, 16'h1234);
        check("t1_lat_en0", {31'd0, lat_en0}, 32'd0);
        check("t1_lat_en1", {31'd0, lat_en1}, 32'd1);
        check("t1_lat_d1",  {24'd0, lat_d1}, {24'd0, fbuf[0]});
        check("t1_bursts",  32'(bursts - base_bursts), 32'd1);
        check("t1_done_at_fall", 32'(done_at_fall - base_fall), 32'd1);

        // 2: last FCS byte corrupted
        build(64, 8'hAB, 8'hCD);
        fbuf[63] = fbuf[63] ^ 8'hFF;
        send_frame(64, -1, -1, 1'b0);
        exp_rx  = 2;
        exp_bad = exp_bad + int'(FCS_EN);
        check_frame("t2", 64, 1, !FCS_EN, 16'hABCD);
`ifdef RX_FCS_CHECK_EN
        check("t2_fcs_err", {31'd0, last_fcs}, 32'd1);
`endif

        // 3: rx_er on data byte 20, then a good frame
        build(64, 8'h56, 8'h78);
        send_frame(64, 20, -1, 1'b0);
        exp_rx = 3; exp_bad++;
        check_frame("t3", 20, 1, 1'b0, 16'h5678);
        check("t3_done_at_fall", 32'(done_at_fall - base_fall), 32'd1);
        build(64, 8'h12, 8'h34);
        send_frame(64, -1, -1, 1'b0);
        exp_rx = 4;
        check_frame("t3b", 64, 1, 1'b1, 16'h1234);

        // 4: 1600-byte overrun, then exactly MAX_LEN, then MIN_LEN-1
        build(1600, 8'h9A, 8'hBC);
        send_frame(1600, -1, -1, 1'b0);
        exp_rx = 5; exp_bad++;
        check_frame("t4", 1518, 1, 1'b0, 16'h9ABC);
        build(1518, 8'h11, 8'h22);
        send_frame(1518, -1, -1, 1'b0);
        exp_rx = 6;
        check_frame("t4max", 1518, 1, 1'b1, 16'h1122);
        build(63, 8'h33, 8'h44);
        send_frame(63, -1, -1, 1'b0);
        exp_rx = 7; exp_bad++;
        check_frame("t4min", 63, 1, 1'b0, 16'h3344);

        // rx_er in the same cycle rx_dv drops
        build(64, 8'h55, 8'h66);
        send_frame(64, -1, -1, 1'b1);
        exp_rx = 8; exp_bad++;
        check_frame("t7", 64, 1, 1'b0, 16'h5566);

        // 5: reset at data byte 30, then a good frame
        build(64, 8'h77, 8'h88);
        send_frame(64, -1, 30, 1'b0);
        exp_rx = 0; exp_bad = 0;
        check("t5_post_en",   {31'd0, post_en}, 32'd0);
        check("t5_post_done", {31'd0, post_done}, 32'd0);
        check("t5_post_seg",  {16'd0, post_seg}, 32'd0);
        check("t5_post_frx",  post_rx, 32'd0);
        check("t5_post_fbad", post_bad, 32'd0);
        check_frame("t5", 30, 0, 1'b0, 16'h0000);
        build(64, 8'h12, 8'h34);
        send_frame(64, -1, -1, 1'b0);
        exp_rx = 1;
        check_frame("t5b", 64, 1, 1'b1, 16'h1234);

        // 6: 10-byte runt, then a bad preamble with stray rx_er
        build(10, 8'hEE, 8'hFF);
        send_frame(10, -1, -1, 1'b0);
        exp_rx = 2; exp_bad = 1;
        check_frame("t6", 10, 1, 1'b0, 16'h1234);
        base_len  = got_q.size();
        base_done = done_cnt;
        @(negedge clk); gmii_rx_dv = 1'b0; gmii_rx_er = 1'b1; gmii_rxd = 8'h00;
        @(negedge clk); gmii_rx_dv = 1'b1; gmii_rx_er = 1'b0; gmii_rxd = 8'h55;
        @(negedge clk); gmii_rxd = 8'h12;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            gmii_rxd   = 8'hAB;
            gmii_rx_er = (i == 4);
        end
        idle(12);
        check("t6_pre_len",  32'(got_q.size() - base_len), 32'd0);
        check("t6_pre_done", 32'(done_cnt - base_done), 32'd0);
        check("t6_pre_frx",  frames_rx, 32'd2);
        check("t6_pre_seg",  {16'd0, seg}, 32'h1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
